// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone bus arbiter.
//   arb_state_t  : arbiter FSM states
//   idx_width()  : bit width needed to index n masters (minimum 1)
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    TOERR = 2'd2
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of every Wishbone signal around the arbiter.
//   wbm_*  : NUM_MASTERS requesting masters (packed, master m in slice m)
//   wbs_*  : the single port toward the SoC interconnect
//   gnt_o / timeout_o : status from the arbiter
// Modport slave is the arbiter's view; modport master is the bench/SoC view.
interface wb_bus_arbiter_if #(parameter int NUM_MASTERS = 2);

  logic [NUM_MASTERS*32-1:0] wbm_adr_i;
  logic [NUM_MASTERS*32-1:0] wbm_dat_i;
  logic [NUM_MASTERS*4-1:0]  wbm_sel_i;
  logic [NUM_MASTERS-1:0]    wbm_we_i;
  logic [NUM_MASTERS-1:0]    wbm_cyc_i;
  logic [NUM_MASTERS-1:0]    wbm_stb_i;
  logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
  logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
  logic [31:0]               wbm_dat_o;
  logic [NUM_MASTERS-1:0]    wbm_ack_o;
  logic [NUM_MASTERS-1:0]    wbm_err_o;
  logic [NUM_MASTERS-1:0]    wbm_rty_o;

  logic [31:0] wbs_adr_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic        wbs_err_i;
  logic        wbs_rty_i;

  logic [NUM_MASTERS-1:0] gnt_o;
  logic                   timeout_o;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
           wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o, gnt_o, timeout_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
           wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o, gnt_o, timeout_o
  );

endinterface

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index with highest priority this round
//   gnt : one-hot winner (first requester at or after ptr, wrapping)
//   idx : binary index of the winner (0 when nothing requests)
module wb_arb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone B4 classic arbiter with a no-response watchdog.
//   wb_clk_i / wb_rst_i : clock, async active-high reset
//   bus (slave modport)  : per-master request/response lanes, the single
//                          interconnect port, gnt_o and timeout_o
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from ptr
// BUSY  | owner's request forwarded, slave responses routed back to it
// TOERR | one cycle: watchdog fired, err to owner, bus strobe suppressed
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  wb_bus_arbiter_if.slave bus
);

  localparam int IW  = idx_width(NUM_MASTERS);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_MASTERS - 1);

  arb_state_t state, state_n;
  logic [NUM_MASTERS-1:0] grant, grant_n, pick_gnt;
  logic [IW-1:0]  gnt_idx, gnt_idx_n, ptr, ptr_n, pick_idx, ptr_after;
  logic [WDW-1:0] wd_cnt, wd_cnt_n;
  logic           g_cyc, g_stb, resp;

  logic [31:0] adr_a [NUM_MASTERS];
  logic [31:0] dat_a [NUM_MASTERS];
  logic [3:0]  sel_a [NUM_MASTERS];
  logic [2:0]  cti_a [NUM_MASTERS];
  logic [1:0]  bte_a [NUM_MASTERS];

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_lane
    assign adr_a[m] = bus.wbm_adr_i[32*m +: 32];
    assign dat_a[m] = bus.wbm_dat_i[32*m +: 32];
    assign sel_a[m] = bus.wbm_sel_i[4*m +: 4];
    assign cti_a[m] = bus.wbm_cti_i[3*m +: 3];
    assign bte_a[m] = bus.wbm_bte_i[2*m +: 2];
  end

  wb_arb_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req (bus.wbm_cyc_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // gnt_idx is held at 0 while idle, so the data-path muxes show master 0 then.
  assign g_cyc     = bus.wbm_cyc_i[gnt_idx];
  assign g_stb     = bus.wbm_stb_i[gnt_idx];
  assign resp      = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign ptr_after = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IW'(1);

  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign bus.gnt_o     = grant;
  assign bus.wbs_adr_o = adr_a[gnt_idx];
  assign bus.wbs_dat_o = dat_a[gnt_idx];
  assign bus.wbs_sel_o = sel_a[gnt_idx];
  assign bus.wbs_cti_o = cti_a[gnt_idx];
  assign bus.wbs_bte_o = bte_a[gnt_idx];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      grant   <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      gnt_idx <= gnt_idx_n;
      ptr     <= ptr_n;
      wd_cnt  <= wd_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    grant_n       = grant;
    gnt_idx_n     = gnt_idx;
    ptr_n         = ptr;
    wd_cnt_n      = '0;
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_we_o  = 1'b0;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    bus.timeout_o = 1'b0;

    case (state)
      IDLE: begin
        if (|bus.wbm_cyc_i) begin
          grant_n   = pick_gnt;
          gnt_idx_n = pick_idx;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        bus.wbs_cyc_o = g_cyc;
        bus.wbs_stb_o = g_stb;
        bus.wbs_we_o  = bus.wbm_we_i[gnt_idx];
        bus.wbm_ack_o = grant & {NUM_MASTERS{bus.wbs_ack_i}};
        bus.wbm_err_o = grant & {NUM_MASTERS{bus.wbs_err_i}};
        bus.wbm_rty_o = grant & {NUM_MASTERS{bus.wbs_rty_i}};
        if (!g_cyc) begin
          state_n   = IDLE;
          grant_n   = '0;
          gnt_idx_n = '0;
          ptr_n     = ptr_after;
        end else if (g_stb && !resp) begin
          if (wd_cnt == WD_LAST) state_n = TOERR;
          else                   wd_cnt_n = wd_cnt + WDW'(1);
        end
      end
      TOERR: begin
        // Any slave response landing here is deliberately discarded.
        bus.wbm_err_o = grant;
        bus.timeout_o = 1'b1;
        if (g_cyc) begin
          state_n = BUSY;
        end else begin
          state_n   = IDLE;
          grant_n   = '0;
          gnt_idx_n = '0;
          ptr_n     = ptr_after;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  wb_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner (-1 = nobody), pending error cycle, rotation start,
  // and how many consecutive unanswered strobe cycles the owner has seen.
  int m_owner, m_ptr, m_wait;
  bit m_toerr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [N-1:0] g;
    int  s;
    bit  busy;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    s    = (m_owner >= 0) ? m_owner : 0;
    busy = (m_owner >= 0) && !m_toerr;
    chk("gnt",     bus.gnt_o,     g);
    chk("wbs_cyc", bus.wbs_cyc_o, busy ? bus.wbm_cyc_i[s] : 1'b0);
    chk("wbs_stb", bus.wbs_stb_o, busy ? bus.wbm_stb_i[s] : 1'b0);
    chk("wbs_we",  bus.wbs_we_o,  busy ? bus.wbm_we_i[s]  : 1'b0);
    chk("wbs_adr", bus.wbs_adr_o, bus.wbm_adr_i[s*32 +: 32]);
    chk("wbs_dat", bus.wbs_dat_o, bus.wbm_dat_i[s*32 +: 32]);
    chk("wbs_sel", bus.wbs_sel_o, bus.wbm_sel_i[s*4 +: 4]);
    chk("wbs_cti", bus.wbs_cti_o, bus.wbm_cti_i[s*3 +: 3]);
    chk("wbs_bte", bus.wbs_bte_o, bus.wbm_bte_i[s*2 +: 2]);
    chk("wbm_ack", bus.wbm_ack_o, (busy && bus.wbs_ack_i) ? g : '0);
    chk("wbm_rty", bus.wbm_rty_o, (busy && bus.wbs_rty_i) ? g : '0);
    chk("wbm_err", bus.wbm_err_o, (m_toerr || (busy && bus.wbs_err_i)) ? g : '0);
    chk("timeout", bus.timeout_o, m_toerr);
    chk("wbm_dat", bus.wbm_dat_o, bus.wbs_dat_i);
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_wait  = 0;
  endtask

  task automatic model_advance();
    bit found;
    int c;
    if (m_owner < 0) begin
      m_wait = 0;
      found  = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && bus.wbm_cyc_i[c]) begin
          found   = 1;
          m_owner = c;
        end
      end
    end else if (m_toerr) begin
      m_toerr = 0;
      m_wait  = 0;
      if (!bus.wbm_cyc_i[m_owner]) model_release();
    end else if (!bus.wbm_cyc_i[m_owner]) begin
      model_release();
    end else if (bus.wbm_stb_i[m_owner] && !(bus.wbs_ack_i || bus.wbs_err_i || bus.wbs_rty_i)) begin
      m_wait++;
      if (m_wait == TO) begin
        m_toerr = 1;
        m_wait  = 0;
      end
    end else begin
      m_wait = 0;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_wait  = 0;
    m_toerr = 0;
  endtask

  // Inputs change at posedge+1; outputs are compared at posedge+5.
  task automatic cyc_check();
    #4;
    model_check();
  endtask

  task automatic cyc_end();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input bit c, input bit s, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    bus.wbm_cyc_i[m] = c;
    bus.wbm_stb_i[m] = s;
    bus.wbm_we_i[m]  = w;
    bus.wbm_adr_i[m*32 +: 32] = a;
    bus.wbm_dat_i[m*32 +: 32] = d;
    bus.wbm_sel_i[m*4 +: 4]   = 4'hF;
    bus.wbm_cti_i[m*3 +: 3]   = 3'(m);
    bus.wbm_bte_i[m*2 +: 2]   = 2'(m);
  endtask

  task automatic set_s(input bit a, input bit e, input bit r);
    bus.wbs_ack_i = a;
    bus.wbs_err_i = e;
    bus.wbs_rty_i = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0;
    bus.wbm_we_i  = '0; bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0;
    bus.wbm_cti_i = '0; bus.wbm_bte_i = '0;
    bus.wbs_dat_i = 32'h1234_5678;
    set_s(0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: bench still running at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    bit dead = 0;
    int r;

    // Single master 1 write, slave acks after two wait states.
    do_reset();
    cyc_check(); chk("rst_gnt", bus.gnt_o, 0); chk("rst_cyc", bus.wbs_cyc_o, 0); cyc_end();
    set_m(1, 1, 1, 1, 32'h2000_0000, 32'hDEAD_BEEF);
    cyc_check(); chk("t1_cyc_req_cycle", bus.wbs_cyc_o, 0); cyc_end();
    cyc_check();
    chk("t1_cyc_next", bus.wbs_cyc_o, 1); chk("t1_gnt", bus.gnt_o, 2'b10);
    chk("t1_adr", bus.wbs_adr_o, 32'h2000_0000); chk("t1_dat", bus.wbs_dat_o, 32'hDEAD_BEEF);
    cyc_end();
    cyc_check(); cyc_end();
    set_s(1, 0, 0);
    cyc_check(); chk("t1_ack", bus.wbm_ack_o, 2'b10); cyc_end();
    set_s(0, 0, 0); set_m(1, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();
    cyc_check(); chk("t1_idle_gnt", bus.gnt_o, 0); cyc_end();

    // Round-robin: both request, m0 first; m0 re-requests at once and waits.
    do_reset();
    set_m(0, 1, 1, 0, 32'h100, 0); set_m(1, 1, 1, 0, 32'h200, 0);
    cyc_check(); cyc_end();
    cyc_check(); chk("rr_first", bus.gnt_o, 2'b01); cyc_end();
    set_m(0, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();
    set_m(0, 1, 1, 0, 32'h104, 0);
    cyc_check(); chk("rr_gap", bus.gnt_o, 0); chk("rr_gap_cyc", bus.wbs_cyc_o, 0); cyc_end();
    cyc_check(); chk("rr_second", bus.gnt_o, 2'b10); chk("rr_adr", bus.wbs_adr_o, 32'h200); cyc_end();
    set_m(1, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();
    cyc_check(); cyc_end();
    cyc_check(); chk("rr_third", bus.gnt_o, 2'b01); cyc_end();

    // m0 keeps cyc over 4 acked strobes while m1 requests: no preemption.
    set_m(1, 1, 1, 0, 32'h300, 0);
    for (int k = 0; k < 4; k++) begin
      set_s(1, 0, 0);
      cyc_check(); chk("hold_gnt", bus.gnt_o, 2'b01); chk("hold_ack", bus.wbm_ack_o, 2'b01); cyc_end();
    end
    set_s(0, 0, 0); set_m(0, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();
    cyc_check(); cyc_end();
    cyc_check(); chk("hold_handover", bus.gnt_o, 2'b10); cyc_end();
    set_m(1, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();

    // Watchdog: stb from cycle S, no response, err + timeout at S+8.
    do_reset();
    set_m(0, 1, 1, 0, 32'h400, 0);
    cyc_check(); cyc_end();
    for (int k = 0; k < TO; k++) begin
      cyc_check(); chk("wd_quiet", bus.timeout_o, 0); chk("wd_stb", bus.wbs_stb_o, 1); cyc_end();
    end
    set_s(1, 0, 0);
    cyc_check();
    chk("wd_fire", bus.timeout_o, 1); chk("wd_err", bus.wbm_err_o, 2'b01);
    chk("wd_stb_low", bus.wbs_stb_o, 0); chk("wd_ack_dropped", bus.wbm_ack_o, 0);
    cyc_end();
    set_s(0, 0, 0); set_m(0, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();
    set_m(1, 1, 1, 1, 32'h500, 32'h55);
    cyc_check(); cyc_end();
    set_s(1, 0, 0);
    cyc_check(); chk("wd_after_ack", bus.wbm_ack_o, 2'b10); chk("wd_after_to", bus.timeout_o, 0); cyc_end();
    set_s(0, 0, 0); set_m(1, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();

    // Async reset mid-wait-state, then master 0 has priority again.
    do_reset();
    set_m(1, 1, 1, 0, 32'h600, 0);
    cyc_check(); cyc_end();
    cyc_check(); cyc_end();
    set_m(1, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();
    set_m(0, 1, 1, 0, 32'h700, 0);
    cyc_check(); cyc_end();
    cyc_check(); chk("ar_pre_gnt", bus.gnt_o, 2'b01);
    #1; rst = 1'b1; set_s(1, 0, 0);
    #1;
    chk("ar_gnt", bus.gnt_o, 0); chk("ar_cyc", bus.wbs_cyc_o, 0);
    chk("ar_ack", bus.wbm_ack_o, 0); chk("ar_err", bus.wbm_err_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; set_s(0, 0, 0);
    set_m(1, 1, 1, 0, 32'h800, 0);
    cyc_check(); cyc_end();
    cyc_check(); chk("ar_prio", bus.gnt_o, 2'b01); cyc_end();
    set_m(0, 0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();
    cyc_check(); cyc_end();

    // rty then err, each clearing the watchdog; m1 waits meanwhile.
    do_reset();
    set_m(0, 1, 1, 0, 32'h900, 0); set_m(1, 1, 1, 0, 32'hA00, 0);
    cyc_check(); cyc_end();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 5; k++) begin
        cyc_check(); chk("re_quiet", bus.timeout_o, 0); cyc_end();
      end
      if (p == 0) begin
        set_s(0, 0, 1);
        cyc_check(); chk("re_rty", bus.wbm_rty_o, 2'b01); chk("re_rty_ack", bus.wbm_ack_o, 0); cyc_end();
      end else if (p == 1) begin
        set_s(0, 1, 0);
        cyc_check(); chk("re_err", bus.wbm_err_o, 2'b01); chk("re_err_to", bus.timeout_o, 0); cyc_end();
      end
      set_s(0, 0, 0);
    end
    set_m(0, 0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0, 0);
    cyc_check(); cyc_end();
    cyc_check(); cyc_end();

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int m = 0; m < N; m++) begin
        if (bus.wbm_cyc_i[m]) begin
          if ($urandom_range(0, 7) == 0) set_m(m, 0, 0, 0, 0, 0);
          else set_m(m, 1, $urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom);
        end else if ($urandom_range(0, 3) == 0) begin
          set_m(m, 1, 1'($urandom), 1'($urandom), $urandom, $urandom);
        end
        bus.wbm_sel_i[m*4 +: 4] = 4'($urandom);
        bus.wbm_cti_i[m*3 +: 3] = 3'($urandom);
        bus.wbm_bte_i[m*2 +: 2] = 2'($urandom);
      end
      if ($urandom_range(0, 49) == 0) dead = !dead;
      r = $urandom_range(0, 9);
      if (dead) set_s(0, 0, 0);
      else set_s(r < 4, r == 4, r == 5);
      bus.wbs_dat_i = $urandom;
      cyc_check();
      cyc_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
